dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port data RAM between the pipeline's memory access (EX/MEM boundary) and a DMA/loader master.
- Sits between the pipeline, the DMA block and the data RAM; the RAM interface is unchanged.
- The CPU has fixed priority. A starvation counter forces a DMA grant after MAX_WAIT denied cycles and stalls the pipeline for that cycle.
- Returns read data to the owner of the previous cycle's access.

Parameters:
- MAX_WAIT, 4: consecutive denied DMA-request cycles before a forced DMA grant (1..15).
- BURST_LEN, 4: maximum beats per DMA burst (DMA_BURST_EN only; 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request (read or write); already address-filtered to RAM range
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  read data for CPU read issued previous cycle
- cpu_stall  out  1  CPU request not granted this cycle; pipeline must hold
- dma_req  in  1  DMA access request; held until granted
- dma_we  in  1  1=write, 0=read
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_gnt  out  1  DMA access performed this cycle
- dma_rvalid  out  1  dma_rdata valid (one cycle after granted DMA read)
- dma_rdata  out  32  DMA read data
- mem_addr  out  32  RAM address
- mem_wdata  out  32  RAM write data
- mem_read  out  1  RAM read enable
- mem_write  out  1  RAM write enable
- mem_rdata  in  32  RAM read data, valid cycle after mem_read

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset); it overrides all other inputs.
- Reset values: wait_cnt=0, last_owner=NONE, dma_rvalid=0, burst_cnt=0. While reset is high, all grant-derived outputs are forced low: cpu_stall=0, dma_gnt=0, mem_read=0, mem_write=0.
- Grant decision is combinational in the same cycle, from the requests and registered wait_cnt:
  - dma_force = dma_req && (wait_cnt == MAX_WAIT).
  - cpu_grant = cpu_req && !dma_force.
  - dma_gnt = dma_req && (!cpu_req || dma_force).
- Derived outputs:
  - cpu_stall = cpu_req && !cpu_grant.
  - mem_* carry the granted port's addr/wdata; mem_read = granted && !we; mem_write = granted && we.
  - With no grant: mem_read=mem_write=0 and mem_addr=mem_wdata=0.
- wait_cnt:
  - Increments when dma_req && !dma_gnt.
  - Clears on dma_gnt or !dma_req.
  - Never exceeds MAX_WAIT.
- last_owner register: NONE/CPU_RD/DMA_RD, set to the port that issued a read this cycle. Writes and idle cycles set NONE.
- Read return:
  - cpu_rdata = mem_rdata when last_owner==CPU_RD, else 0.
  - dma_rvalid registered, 1 iff last_owner will be DMA_RD; dma_rdata = mem_rdata when dma_rvalid, else 0.
- Latency: writes take 0 cycles (committed at the granted edge). Reads take 1 cycle.
- Stall rules:
  - A stalled CPU request must be re-presented unchanged; the arbiter keeps no CPU state.
  - A forced grant costs exactly one stall cycle. After it, wait_cnt=0, so the CPU wins the next MAX_WAIT contested cycles.
- Simultaneous dma_req deassert and force condition: no grant, wait_cnt clears.
- Reset mid-read: the pending return is dropped and dma_rvalid=0 the next cycle.

Optional Feature:
- Macro DMA_BURST_EN.
- When defined:
  - Once DMA is granted uncontested (cpu_req=0), the arbiter enters state DMA_BURST and keeps DMA ownership for up to BURST_LEN consecutive beats while dma_req stays high.
  - cpu_stall=1 for any cpu_req during the burst.
  - burst_cnt counts beats. The burst ends at BURST_LEN beats or on dma_req=0, whichever comes first; the arbiter then returns to ARB and wait_cnt=0.
  - A forced grant is a single beat, not a burst.
- When undefined: ARB state only; every cycle is arbitrated independently.

Test Plan:
1. CPU only, write 0x1234 to addr 0x10, then read 0x10 -> mem_write=1 in cycle 0; cpu_rdata=0x1234 in the cycle after the read; cpu_stall stays 0.
2. DMA only, read addr 0x20 (RAM holds 0xCAFE) -> dma_gnt=1 same cycle; next cycle dma_rvalid=1 and dma_rdata=0xCAFE.
3. Contention with MAX_WAIT=4, cpu_req and dma_req held high -> CPU granted cycles 0-3; cycle 4 dma_gnt=1 and cpu_stall=1; pattern repeats with period 5.
4. Read-return routing: CPU read 0x30 (=0x1) then DMA read 0x34 (=0x2) back-to-back -> cpu_rdata=0x1 in cycle 1 with dma_rvalid=0; cycle 2 dma_rvalid=1, dma_rdata=0x2.
5. Reset asserted in the cycle after a DMA read grant -> dma_rvalid=0 next cycle; wait_cnt=0; mem_read/mem_write=0 while reset is high.
6. DMA_BURST_EN, BURST_LEN=4: DMA requests for 6 beats with cpu_req rising at beat 1 -> dma_gnt beats 0-3 with cpu_stall=1 on beats 1-3; beat 4 CPU granted and DMA denied.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data RAM between the pipeline's memory stage (CPU
// port) and a DMA/loader master. The CPU port has fixed priority. A DMA
// request that has been denied for MAX_WAIT consecutive cycles is granted
// anyway, and the CPU is stalled for that one cycle. Read data coming back
// from the RAM one cycle later is routed to whichever port issued the read.
//
// Optional feature (compile-time macro DMA_BURST_EN):
//   When DMA is granted with no competing CPU request, it keeps the RAM for up
//   to BURST_LEN consecutive beats while dma_req stays high. Any CPU request
//   during the burst is stalled. A forced (anti-starvation) grant is always a
//   single beat. Without the macro, every cycle is arbitrated independently.
//
// Parameters:
//   MAX_WAIT   denied DMA cycles before a forced DMA grant (1..15)
//   BURST_LEN  maximum beats per DMA burst, DMA_BURST_EN only (1..15)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       CPU access request (held while stalled)
//   cpu_rdata                   data for the CPU read granted last cycle
//   cpu_stall                   CPU request not granted this cycle
//   dma_req/we/addr/wdata       DMA access request (held until granted)
//   dma_gnt                     DMA access performed this cycle
//   dma_rvalid, dma_rdata       DMA read return, one cycle after the grant
//   mem_addr/wdata/read/write   RAM command for this cycle
//   mem_rdata                   RAM read data, valid the cycle after mem_read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    // Owner of the read issued in the previous cycle.
    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_CPU_RD = 2'd1;
    localparam logic [1:0] OWN_DMA_RD = 2'd2;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic [1:0] last_owner;
    logic [1:0] owner_nxt;
    logic       dma_force;
    logic       cpu_grant;
    logic       dma_grant;
    logic       burst_hold;   // DMA owns the RAM this cycle as part of a burst

`ifdef DMA_BURST_EN
    localparam logic [0:0] ST_ARB       = 1'b0;
    localparam logic [0:0] ST_DMA_BURST = 1'b1;
    localparam logic [3:0] BURST_LEN_C  = 4'(BURST_LEN);

    logic [0:0] state;
    logic [3:0] burst_cnt;

    // A burst only continues while DMA keeps requesting; a dropped request
    // ends it immediately and the CPU may use that same cycle.
    assign burst_hold = (state == ST_DMA_BURST) && dma_req;
`else
    logic unused_burst_len;

    assign burst_hold       = 1'b0;
    assign unused_burst_len = (BURST_LEN == 0);
`endif

    // ------------------------------------------------------------------
    // Grant decision (same cycle, from requests and registered wait_cnt)
    // ------------------------------------------------------------------
    assign dma_force = dma_req && (wait_cnt == MAX_WAIT_C);
    assign cpu_grant = !reset && !burst_hold && cpu_req && !dma_force;
    assign dma_grant = !reset && dma_req && (burst_hold || !cpu_req || dma_force);

    assign dma_gnt   = dma_grant;
    assign cpu_stall = !reset && cpu_req && !cpu_grant;

    // RAM command mux; the bus is driven to zero when nobody is granted.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        owner_nxt = OWN_NONE;
        if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = !cpu_we;
            mem_write = cpu_we;
            owner_nxt = cpu_we ? OWN_NONE : OWN_CPU_RD;
        end else if (dma_grant) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_read  = !dma_we;
            mem_write = dma_we;
            owner_nxt = dma_we ? OWN_NONE : OWN_DMA_RD;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter and read-return bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            wait_cnt   <= '0;
            last_owner <= OWN_NONE;
            dma_rvalid <= 1'b0;
        end else begin
            last_owner <= owner_nxt;
            dma_rvalid <= (owner_nxt == OWN_DMA_RD);
            if (!dma_req || dma_grant) begin
                wait_cnt <= '0;
            end else if (wait_cnt != MAX_WAIT_C) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign cpu_rdata = (last_owner == OWN_CPU_RD) ? mem_rdata : '0;
    assign dma_rdata = dma_rvalid ? mem_rdata : '0;

`ifdef DMA_BURST_EN
    // ------------------------------------------------------------------
    // Burst tracking: beat 0 is the uncontested grant taken in ST_ARB,
    // burst_cnt counts beats already performed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ARB;
            burst_cnt <= '0;
        end else if (state == ST_ARB) begin
            if (dma_grant && !cpu_req && !dma_force && (BURST_LEN > 1)) begin
                state     <= ST_DMA_BURST;
                burst_cnt <= 4'd1;
            end
        end else if (burst_hold) begin
            if (burst_cnt + 4'd1 == BURST_LEN_C) begin
                state     <= ST_ARB;
                burst_cnt <= '0;
            end else begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end else begin
            state     <= ST_ARB;
            burst_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed scenarios with constant expectations, followed by a randomized run
// checked against a behavioural model (priority rules, denied-cycle streak,
// burst beat count, shadow memory). The bench also plays the RAM.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int BURST_LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, dma_gnt, dma_rvalid, mem_read, mem_write;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, 256 words.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= ram[mem_addr[9:2]];
    end

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic rst,
                         input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        reset = rst;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h5, 1'b1, 1'b1, 32'h44, 32'h6);
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_stall: got %0h want 0", cpu_stall); end
        n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_dma_gnt: got %0h want 0", dma_gnt); end
        n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rw: got rd=%0h wr=%0h want 0/0", mem_read, mem_write); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_dma_rvalid: got %0h want 0", dma_rvalid); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        idle();
    endtask

    task automatic test_cpu_only();
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_cmd: got rd=%0h wr=%0h want 0/1", mem_read, mem_write); end
        n_checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'h1234) begin n_fail++; $display("FAIL cpu_wr_bus: got %h/%h want 10/1234", mem_addr, mem_wdata); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_stall: got %0h want 0", cpu_stall); end
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (mem_read !== 1'b1 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_cmd: got rd=%0h stall=%0h want 1/0", mem_read, cpu_stall); end
        idle();
        n_checks++; if (cpu_rdata !== 32'h1234) begin n_fail++; $display("FAIL cpu_rd_data: got %h want 1234", cpu_rdata); end
        idle();
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL cpu_rd_data_idle: got %h want 0", cpu_rdata); end
    endtask

    task automatic test_dma_only();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFE);
        n_checks++; if (dma_gnt !== 1'b1 || mem_write !== 1'b1) begin n_fail++; $display("FAIL dma_wr: got gnt=%0h wr=%0h want 1/1", dma_gnt, mem_write); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        n_checks++; if (dma_gnt !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 32'h20) begin n_fail++; $display("FAIL dma_rd_cmd: got gnt=%0h rd=%0h addr=%h want 1/1/20", dma_gnt, mem_read, mem_addr); end
        n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dma_rvalid_early: got %0h want 0", dma_rvalid); end
        idle();
        n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hCAFE) begin n_fail++; $display("FAIL dma_rd_data: got v=%0h d=%h want 1/cafe", dma_rvalid, dma_rdata); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL dma_rd_cpu_leak: got %h want 0", cpu_rdata); end
        idle();
        n_checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0) begin n_fail++; $display("FAIL dma_rvalid_drop: got v=%0h d=%h want 0/0", dma_rvalid, dma_rdata); end
    endtask

    task automatic test_contention();
        logic exp_f;
        idle();
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
            exp_f = ((i % 5) == 4);
            n_checks++; if (dma_gnt !== exp_f || cpu_stall !== exp_f) begin n_fail++; $display("FAIL contention_c%0d: got gnt=%0h stall=%0h want %0h/%0h", i, dma_gnt, cpu_stall, exp_f, exp_f); end
            n_checks++; if (mem_addr !== (exp_f ? 32'h200 : 32'h100 + 32'(4 * i))) begin n_fail++; $display("FAIL contention_addr_c%0d: got %h", i, mem_addr); end
        end
        // Force condition coincides with DMA dropping its request.
        idle();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h200, 32'h0);
        n_checks++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL force_drop: got gnt=%0h stall=%0h want 0/0", dma_gnt, cpu_stall); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
            n_checks++; if (dma_gnt !== (i == 4)) begin n_fail++; $display("FAIL wait_cleared_c%0d: got gnt=%0h want %0h", i, dma_gnt, (i == 4)); end
        end
        idle();
    endtask

    task automatic test_read_routing();
        drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h34, 32'h2);
        drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (cpu_stall !== 1'b0 || mem_read !== 1'b1) begin n_fail++; $display("FAIL route_cpu_rd: got stall=%0h rd=%0h want 0/1", cpu_stall, mem_read); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
        n_checks++; if (cpu_rdata !== 32'h1 || dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL route_c1: got cpu=%h v=%0h want 1/0", cpu_rdata, dma_rvalid); end
        idle();
        n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h2 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL route_c2: got v=%0h d=%h cpu=%h want 1/2/0", dma_rvalid, dma_rdata, cpu_rdata); end
    endtask

    task automatic test_reset_mid_read();
        idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
        n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got rd=%0h wr=%0h gnt=%0h stall=%0h want 0", mem_read, mem_write, dma_gnt, cpu_stall); end
        idle();
        n_checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rvalid: got v=%0h d=%h want 0/0", dma_rvalid, dma_rdata); end
        // Build up denied cycles, reset, then the full MAX_WAIT window must apply again.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
            n_checks++; if (dma_gnt !== (i == 4)) begin n_fail++; $display("FAIL midrst_wait_c%0d: got gnt=%0h want %0h", i, dma_gnt, (i == 4)); end
        end
        idle();
    endtask

`ifdef DMA_BURST_EN
    task automatic test_burst();
        idle();
        for (int b = 0; b < 6; b++) begin
            drive(1'b0, (b >= 1), 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h400 + 32'(4 * b), 32'h0);
            n_checks++; if (dma_gnt !== (b <= 3)) begin n_fail++; $display("FAIL burst_gnt_b%0d: got %0h want %0h", b, dma_gnt, (b <= 3)); end
            n_checks++; if (cpu_stall !== (b >= 1 && b <= 3)) begin n_fail++; $display("FAIL burst_stall_b%0d: got %0h want %0h", b, cpu_stall, (b >= 1 && b <= 3)); end
        end
        idle();
    endtask
`endif

    // ------------------------------------------------------------------
    // Randomized run against a behavioural model.
    // ------------------------------------------------------------------
    task automatic test_random();
        logic [31:0] m_mem [256];
        int          m_streak, m_beats;
        logic [31:0] e_cpu_rdata, e_dma_rdata;
        logic        e_dma_rvalid;
        logic        cr, cw, dr, dw, in_burst, forced, x_dma, x_cpu, x_stall, x_rd, x_wr;
        logic [31:0] ca, cd, da, dd, x_addr, x_wdata;
        logic        prev_stall, prev_dgnt;

        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        m_streak = 0; m_beats = 0;
        e_cpu_rdata = '0; e_dma_rdata = '0; e_dma_rvalid = 1'b0;
        prev_stall = 1'b0; prev_dgnt = 1'b0;
        cr = 1'b0; cw = 1'b0; ca = '0; cd = '0; dr = 1'b0; dw = 1'b0; da = '0; dd = '0;

        for (int cyc = 0; cyc < 256 + 400; cyc++) begin
            if (cyc < 256) begin
                // Preload every word through the DMA port.
                cr = 1'b0; dr = 1'b1; dw = 1'b1; da = 32'(cyc * 4); dd = $urandom;
            end else begin
                if (!(cr && prev_stall)) begin
                    cr = ($urandom_range(0, 99) < 60); cw = ($urandom_range(0, 1) == 1);
                    ca = {22'h0, 8'($urandom_range(0, 255)), 2'b00}; cd = $urandom;
                end
                if (!(dr && !prev_dgnt && $urandom_range(0, 19) != 0)) begin
                    dr = ($urandom_range(0, 99) < 50); dw = ($urandom_range(0, 1) == 1);
                    da = {22'h0, 8'($urandom_range(0, 255)), 2'b00}; dd = $urandom;
                end
            end
            drive(1'b0, cr, cw, ca, cd, dr, dw, da, dd);

            in_burst = (m_beats > 0) && dr;
            forced   = dr && (m_streak == MAX_WAIT);
            x_dma    = dr && (in_burst || !cr || forced);
            x_cpu    = cr && !x_dma;
            x_stall  = cr && !x_cpu;
            x_rd     = (x_cpu && !cw) || (x_dma && !dw);
            x_wr     = (x_cpu && cw) || (x_dma && dw);
            x_addr   = x_cpu ? ca : (x_dma ? da : 32'h0);
            x_wdata  = x_cpu ? cd : (x_dma ? dd : 32'h0);

            n_checks++; if (dma_gnt !== x_dma) begin n_fail++; $display("FAIL rnd_dma_gnt c%0d: got %0h want %0h", cyc, dma_gnt, x_dma); end
            n_checks++; if (cpu_stall !== x_stall) begin n_fail++; $display("FAIL rnd_cpu_stall c%0d: got %0h want %0h", cyc, cpu_stall, x_stall); end
            n_checks++; if (mem_read !== x_rd || mem_write !== x_wr) begin n_fail++; $display("FAIL rnd_mem_rw c%0d: got %0h/%0h want %0h/%0h", cyc, mem_read, mem_write, x_rd, x_wr); end
            n_checks++; if (mem_addr !== x_addr || mem_wdata !== x_wdata) begin n_fail++; $display("FAIL rnd_mem_bus c%0d: got %h/%h want %h/%h", cyc, mem_addr, mem_wdata, x_addr, x_wdata); end
            n_checks++; if (cpu_rdata !== e_cpu_rdata) begin n_fail++; $display("FAIL rnd_cpu_rdata c%0d: got %h want %h", cyc, cpu_rdata, e_cpu_rdata); end
            n_checks++; if (dma_rvalid !== e_dma_rvalid || dma_rdata !== e_dma_rdata) begin n_fail++; $display("FAIL rnd_dma_rd c%0d: got %0h/%h want %0h/%h", cyc, dma_rvalid, dma_rdata, e_dma_rvalid, e_dma_rdata); end

            // Model update for the coming clock edge.
            e_cpu_rdata  = (x_cpu && !cw) ? m_mem[ca[9:2]] : 32'h0;
            e_dma_rvalid = x_dma && !dw;
            e_dma_rdata  = e_dma_rvalid ? m_mem[da[9:2]] : 32'h0;
            if (x_cpu && cw) m_mem[ca[9:2]] = cd;
            if (x_dma && dw) m_mem[da[9:2]] = dd;
`ifdef DMA_BURST_EN
            if (!dr) m_beats = 0;
            else if (in_burst) begin
                m_beats++;
                if (m_beats == BURST_LEN) m_beats = 0;
            end else if (x_dma && !cr && !forced && BURST_LEN > 1) m_beats = 1;
`endif
            m_streak   = (!dr || x_dma) ? 0 : m_streak + 1;
            prev_stall = x_stall;
            prev_dgnt  = x_dma;
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        test_reset();
        test_cpu_only();
        test_dma_only();
        test_contention();
        test_read_routing();
        test_reset_mid_read();
`ifdef DMA_BURST_EN
        test_burst();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
